// File: rtl/scan_pkg.sv
// scan_pkg: shared state type and word-count helper for scan_fifo_drain
package scan_pkg;
   typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, DONE} drain_state_t;
   function automatic int word_count(input int chain_len, input int width);
      return (chain_len + width - 1) / width;
   endfunction
endpackage

// File: rtl/scan_word_shreg.sv
// scan_word_shreg: word shift register, LSB first, with remaining-bit counter
module scan_word_shreg #(
   parameter int WIDTH = 32,
   localparam int WW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   input  logic [WW-1:0]    load_bits,
   output logic             bit0,
   output logic             last
);
   logic [WIDTH-1:0] shreg;
   logic [WW-1:0]    word_bits;
   always_ff @(posedge clk)
      if (rst) begin
         shreg <= '0;
         word_bits <= '0;
      end else if (load) begin
         shreg <= data;
         word_bits <= load_bits;
      end else if (shift) begin
         shreg <= shreg >> 1;
         word_bits <= word_bits - 1'b1;
      end
   assign bit0 = shreg[0];
   assign last = word_bits == WW'(1);
endmodule

// File: rtl/scan_fifo_drain.sv
// scan_fifo_drain: pops FIFO words and shifts CHAIN_LEN bits LSB-first onto a scan chain
// Optional parity output enabled by SCAN_FIFO_DRAIN_PARITY_EN.
module scan_fifo_drain
   import scan_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHAIN_LEN = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             fifo_empty,
   output logic             fifo_read,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             scan_out,
   output logic             scan_enable,
   output logic             busy,
   output logic             done
`ifdef SCAN_FIFO_DRAIN_PARITY_EN
   ,
   output logic             parity
`endif
);
   localparam int BW = $clog2(CHAIN_LEN + 1);
   localparam int WW = $clog2(WIDTH + 1);
   drain_state_t  state;
   logic [BW-1:0] bits_left;
   logic [WW-1:0] load_bits;
   logic          bit0, last;
   assign load_bits = (int'(bits_left) >= WIDTH) ? WW'(WIDTH) : WW'(bits_left);
   scan_word_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .load     (state == LOAD),
      .shift    (state == SHIFT),
      .data     (fifo_data),
      .load_bits(load_bits),
      .bit0     (bit0),
      .last     (last)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         bits_left <= '0;
      end else
         case (state)
            IDLE: if (start) begin
               bits_left <= BW'(CHAIN_LEN);
               state <= POP;
            end
            POP: if (!fifo_empty) state <= LOAD;
            LOAD: state <= SHIFT;
            SHIFT: begin
               bits_left <= bits_left - 1'b1;
               if (last) state <= (bits_left == BW'(1)) ? DONE : POP;
            end
            default: state <= IDLE;
         endcase
   // scan_out is gated so stale upper bits of a partial word never leak out
   always_comb begin
      fifo_read = (state == POP) && !fifo_empty;
      scan_enable = state == SHIFT;
      scan_out = (state == SHIFT) && bit0;
      busy = state != IDLE;
      done = state == DONE;
   end
`ifdef SCAN_FIFO_DRAIN_PARITY_EN
   always_ff @(posedge clk)
      if (rst) parity <= 1'b0;
      else if (state == IDLE && start) parity <= 1'b0;
      else if (state == SHIFT) parity <= parity ^ bit0;
`endif
endmodule

// File: tb/tb_scan_fifo_drain.sv
// tb_scan_fifo_drain: randomized and directed checks of two drain instances (chain 12 and 16)
module tb_scan_fifo_drain;
   import scan_pkg::*;
   logic       clk = 1'b0;
   logic       rst;
   logic       start [2];
   logic       empty [2];
   logic       rd [2];
   logic [7:0] data [2];
   logic       so [2];
   logic       en [2];
   logic       busy [2];
   logic       done [2];
`ifdef SCAN_FIFO_DRAIN_PARITY_EN
   logic       par [2];
`endif
   logic [7:0] mem [2][256];
   int         n_push [2] = '{0, 0};
   int         n_pop [2] = '{0, 0};
   int         nb [2] = '{0, 0};
   int         npop [2] = '{0, 0};
   int         ndone [2] = '{0, 0};
   int         rd_empty [2] = '{0, 0};
   logic       bit_m [2][2048];
   int         bit_t [2][2048];
   int         rd_t [2][512];
   int         done_t [2][256];
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign empty[g] = n_push[g] == n_pop[g];
      scan_fifo_drain #(.WIDTH(8), .CHAIN_LEN(g ? 16 : 12)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start[g]),
         .fifo_empty (empty[g]),
         .fifo_read  (rd[g]),
         .fifo_data  (data[g]),
         .scan_out   (so[g]),
         .scan_enable(en[g]),
         .busy       (busy[g]),
         .done       (done[g])
`ifdef SCAN_FIFO_DRAIN_PARITY_EN
         ,
         .parity     (par[g])
`endif
      );
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++)
         if (rd[d]) begin
            data[d] <= mem[d][n_pop[d] % 256];
            n_pop[d] <= n_pop[d] + 1;
         end
   end

   always @(negedge clk)
      for (int d = 0; d < 2; d++) begin
         if (en[d]) begin
            bit_m[d][nb[d]] = so[d];
            bit_t[d][nb[d]] = cyc;
            nb[d] = nb[d] + 1;
         end
         if (rd[d]) begin
            rd_t[d][npop[d]] = cyc;
            npop[d] = npop[d] + 1;
            if (empty[d]) rd_empty[d] = rd_empty[d] + 1;
         end
         if (done[d]) begin
            done_t[d][ndone[d]] = cyc;
            ndone[d] = ndone[d] + 1;
         end
      end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic push(input int d, input logic [7:0] w);
      mem[d][n_push[d] % 256] = w;
      n_push[d]++;
   endtask

   task automatic chk_idle(input int d, input string tag);
      chk({tag, ":outs"}, {rd[d], en[d], so[d], busy[d], done[d]}, 0);
   endtask

   // Reference: the chain sees the FIFO words from the read pointer, LSB first, truncated to L bits.
   task automatic op(input int d, input logic [7:0] w0, input logic [7:0] w1,
                     input int gap, input int mid, input string tag);
      int         l, nw, ptr, b_nb, b_pop, b_done, t0, k;
      logic [15:0] exp_v, obs_v;
      logic [7:0] w;
      logic       p;
      l = d ? 16 : 12;
      nw = word_count(l, 8);
      push(d, w0);
      if (gap == 0) push(d, w1);
      ptr = n_pop[d];
      b_nb = nb[d];
      b_pop = npop[d];
      b_done = ndone[d];
      t0 = cyc;
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      k = 0;
      while (ndone[d] == b_done && k < 200) begin
         if (gap > 0 && k == gap) push(d, w1);
         if (gap >= 15 && k == gap - 1)
            chk({tag, ":stall"}, {en[d], busy[d], rd[d]}, 3'b010);
         start[d] = k == mid;
         @(negedge clk);
         k++;
      end
      start[d] = 1'b0;
      chk({tag, ":timeout"}, k < 200, 1);
      repeat (4) @(negedge clk);
      exp_v = '0;
      obs_v = '0;
      p = 1'b0;
      for (int i = 0; i < l; i++) begin
         w = mem[d][(ptr + i / 8) % 256];
         exp_v[i] = w[i % 8];
         obs_v[i] = bit_m[d][b_nb + i];
         p ^= exp_v[i];
      end
      chk({tag, ":nbits"}, nb[d] - b_nb, l);
      chk({tag, ":stream"}, obs_v, exp_v);
      chk({tag, ":pops"}, npop[d] - b_pop, nw);
      chk({tag, ":dones"}, ndone[d] - b_done, 1);
      chk({tag, ":done_t"}, done_t[d][b_done], bit_t[d][b_nb + l - 1] + 1);
      chk({tag, ":rd_t"}, rd_t[d][b_pop], t0 + 1);
      chk({tag, ":en_t"}, bit_t[d][b_nb], t0 + 3);
      chk({tag, ":rd_empty"}, rd_empty[d], 0);
      chk({tag, ":busy"}, busy[d], 0);
`ifdef SCAN_FIFO_DRAIN_PARITY_EN
      chk({tag, ":parity"}, par[d], p);
`endif
   endtask

   initial begin
      int b_pop;
      rst = 1'b1;
      start[0] = 1'b0;
      start[1] = 1'b0;
      repeat (2) @(negedge clk);
      chk_idle(0, "reset0");
      chk_idle(1, "reset1");
      rst = 1'b0;
      @(negedge clk);
      op(0, 8'hA5, 8'h03, 0, -1, "basic");
      op(0, 8'hA5, 8'h03, 20, -1, "stall");
      op(0, 8'h5A, 8'hC3, 0, 5, "midstart");
      op(1, 8'hFF, 8'h00, 0, -1, "exact");
      op(0, 8'hA7, 8'h03, 0, -1, "par1");
      op(0, 8'hA5, 8'h03, 0, -1, "par0");
      push(0, 8'h5A);
      push(0, 8'h3C);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_idle(0, "rst_mid");
      @(negedge clk);
      rst = 1'b0;
      b_pop = npop[0];
      repeat (10) @(negedge clk);
      chk("rst_nopop", npop[0] - b_pop, 0);
      chk_idle(0, "rst_after");
      for (int i = 0; i < 8; i++)
         op(int'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 24)),
            $urandom_range(0, 1) ? -1 : int'($urandom_range(1, 8)), "rand");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/scan_fifo_drain.md
# scan_fifo_drain

Consumer end of the scan-snapshot FIFO. It pops WIDTH-bit words from an upstream `fifo` instance and serializes them LSB-first onto a DUT scan chain of CHAIN_LEN bits, driving scan_enable only while a valid bit is on scan_out. It sits between the snapshot-restore FIFO and the scan chain input of the instrumented design, one instance per chain.

## Interface

Parameters:
- WIDTH, 32, FIFO word width; must match the upstream FIFO.
- CHAIN_LEN, 100, total scan-chain bits shifted per operation; must be ≥1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to shift a full chain; ignored while busy.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_read  output  1  pop strobe to the upstream FIFO; one cycle per word.
- fifo_data  input  WIDTH  upstream FIFO data_out; valid the cycle after fifo_read.
- scan_out  output  1  serial bit to the chain's scan input.
- scan_enable  output  1  chain shift enable; high exactly on cycles where scan_out is a valid bit.
- busy  output  1  high from the cycle after accepted start through the done cycle.
- done  output  1  one-cycle pulse after the last bit is shifted.
- parity  output  1  XOR of all shifted bits; present only with SCAN_FIFO_DRAIN_PARITY_EN.

## Operation

- States: IDLE, POP, LOAD, SHIFT, DONE.
- IDLE: all outputs 0. On start, load bits_left = CHAIN_LEN, go to POP.
- POP: if fifo_empty = 0, assert fifo_read for this cycle, go to LOAD; else stall in POP with fifo_read = 0 and scan_enable = 0 (chain holds).
- LOAD: latch fifo_data into the shift register; word_bits = min(WIDTH, bits_left); go to SHIFT.
- SHIFT: scan_out = shreg[0], scan_enable = 1; shreg shifts right by one and bits_left, word_bits decrement each cycle. When word_bits reaches 0: if bits_left = 0 go to DONE, else go to POP.
- DONE: done = 1 for one cycle, go to IDLE.
- Partial last word: when CHAIN_LEN is not a multiple of WIDTH, only the low CHAIN_LEN mod WIDTH bits of the final word are shifted; the upper bits are discarded and the word is still popped.
- Words popped per operation = ceil(CHAIN_LEN / WIDTH), exactly.
- Counters: bits_left is $clog2(CHAIN_LEN+1) bits; word_bits is $clog2(WIDTH+1) bits; no wrap.
- start in any non-IDLE state is ignored with no side effect.
- Reset at any cycle: next state IDLE, every output 0, shift register and counters cleared; no fifo_read after the reset cycle.

## Timing

- Reset value of every output: 0.
- start at cycle T (FIFO non-empty): fifo_read at T+1, first scan_enable at T+3.
- Per word: 2 bubble cycles (POP, LOAD) and then word_bits shift cycles; scan_enable is low in the bubbles.
- done is asserted one cycle after the final scan_enable cycle. busy deasserts on the cycle after done.
- fifo_read is never asserted when fifo_empty = 1 in the same cycle.

## Configuration

- SCAN_FIFO_DRAIN_PARITY_EN defined: a parity register is cleared on accepted start and XORs scan_out on every scan_enable cycle. It is valid from the done cycle and holds until the next accepted start or reset.
- Undefined: the parity port and register are absent.

## Structure

- The shared package scan_pkg holds the state enum type (drain_state_t) and a helper constant function for the word count, ceil(CHAIN_LEN/WIDTH).
- The shift register, with its load, shift and word_bits counter, is a natural sub-module: scan_word_shreg, parameterized by WIDTH.
- The FSM and bits_left counter stay in scan_fifo_drain.

## Test plan

Parameters WIDTH=8, CHAIN_LEN=12 unless noted.
- Reset: hold rst 2 cycles during a shift. Required: all outputs 0 on the next cycle, state IDLE, no fifo_read afterwards.
- Basic drain: FIFO holds 0xA5, 0x03; pulse start. Required: scan_out on scan_enable cycles = 1,0,1,0,0,1,0,1 then 1,1,0,0; fifo_read asserted exactly twice; done 1 cycle after the 12th bit.
- Empty stall: only 0xA5 present. Required: after 8 bits the block stalls in POP with scan_enable = 0 and busy = 1; push 0x03 and the remaining 1,1,0,0 follow, then done.
- Start while busy: pulse start mid-shift. Required: the bit stream and pop count are unchanged; exactly one done.
- Exact multiple: CHAIN_LEN=16, FIFO holds 0xFF, 0x00. Required: 8 ones then 8 zeros, 2 pops, done.
- Parity (macro defined): FIFO holds 0xA7, 0x03 with CHAIN_LEN=12. Required: parity = 1 at done (5+2 = 7 ones shifted). With 0xA5, 0x03: parity = 0.
